// File: rtl/regn_file.sv
// regn_file -- parametrised register bank with a per-register busy scoreboard.
//
// Storage is NREGS x WIDTH with one synchronous write port and two
// combinational read ports. Every register also has a busy bit. The control
// FSM sets a register's busy bit when it issues an instruction that writes that
// register, and the writeback to that register clears it. The control can then
// stall while an operand is still pending.
//
// Parameters:
//   WIDTH      data bits per register
//   NREGS      number of registers (2..256)
//   AW         address width, at least clog2(NREGS)
//   ZERO_REG0  1: register 0 reads 0, ignores writes and is never busy
//   RESET_VAL  value loaded into every register on reset
//
// Ports:
//   Clock              rising-edge clock
//   Resetn             synchronous active-low reset (clears contents and busy bits)
//   WrEn/WrAddr/WrData write port; a write also clears the target busy bit
//   SetBusy/BusyAddr   mark a register pending
//   RdAddrA/RdDataA/BusyA  read port A (combinational)
//   RdAddrB/RdDataB/BusyB  read port B (combinational)
//   BusyVec            busy bit per register, bit i = register i
//
// Build option:
//   REGN_FILE_BYPASS_EN  when defined, a read port whose index matches an
//                        accepted write in the same cycle returns WrData
//                        and reports not-busy. Storage timing is the same
//                        in both builds.

module regn_file #(
  parameter int               WIDTH     = 16,
  parameter int               NREGS     = 8,
  parameter int               AW        = 3,
  parameter bit               ZERO_REG0 = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             SetBusy,
  input  logic [AW-1:0]    BusyAddr,
  input  logic [AW-1:0]    RdAddrA,
  output logic [WIDTH-1:0] RdDataA,
  output logic             BusyA,
  input  logic [AW-1:0]    RdAddrB,
  output logic [WIDTH-1:0] RdDataB,
  output logic             BusyB,
  output logic [NREGS-1:0] BusyVec
);

  logic [WIDTH-1:0] regs_p0 [NREGS];
  logic [NREGS-1:0] busy_p0;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_ok;
  logic             set_ok;

  // A write or busy-set is accepted only if its index is in range and it does
  // not target a hardwired-zero register 0. Rejected requests change nothing.
  assign wr_ok  = WrEn && (int'(WrAddr) < NREGS) &&
                  !(ZERO_REG0 && (WrAddr == '0));
  assign set_ok = SetBusy && (int'(BusyAddr) < NREGS) &&
                  !(ZERO_REG0 && (BusyAddr == '0));

  // The write clears its target first and the set is applied afterwards. When
  // both name the same register, the set therefore wins: the newly issued
  // producer supersedes the one that is completing.
  always_comb begin
    busy_nxt = busy_p0;
    for (int i = 0; i < NREGS; i++) begin
      if (wr_ok && (int'(WrAddr) == i)) busy_nxt[i] = 1'b0;
    end
    for (int i = 0; i < NREGS; i++) begin
      if (set_ok && (int'(BusyAddr) == i)) busy_nxt[i] = 1'b1;
    end
  end

  // ---- storage stage p0 ----
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NREGS; i++) regs_p0[i] <= RESET_VAL;
      busy_p0 <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_ok && (int'(WrAddr) == i)) regs_p0[i] <= WrData;
      end
      busy_p0 <= busy_nxt;
    end
  end

  assign BusyVec = busy_p0;

  // Read port A. An out-of-range index matches no entry, so it reads 0 and
  // reports not-busy.
  always_comb begin
    RdDataA = '0;
    BusyA   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if ((int'(RdAddrA) == i) && !(ZERO_REG0 && (i == 0))) begin
        RdDataA = regs_p0[i];
        BusyA   = busy_p0[i];
      end
    end
`ifdef REGN_FILE_BYPASS_EN
    if (wr_ok && (RdAddrA == WrAddr)) begin
      RdDataA = WrData;
      BusyA   = 1'b0;
    end
`endif
  end

  // Read port B, identical to port A.
  always_comb begin
    RdDataB = '0;
    BusyB   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if ((int'(RdAddrB) == i) && !(ZERO_REG0 && (i == 0))) begin
        RdDataB = regs_p0[i];
        BusyB   = busy_p0[i];
      end
    end
`ifdef REGN_FILE_BYPASS_EN
    if (wr_ok && (RdAddrB == WrAddr)) begin
      RdDataB = WrData;
      BusyB   = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regn_file.sv
module tb_regn_file;

  logic        Clock;
  logic        Resetn;
  logic        WrEn;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic        SetBusy;
  logic [2:0]  BusyAddr;
  logic [2:0]  RdAddrA;
  logic [2:0]  RdAddrB;

  logic [15:0] RdDataA, RdDataB;
  logic        BusyA, BusyB;
  logic [7:0]  BusyVec;

  logic [15:0] RdDataA6, RdDataB6;
  logic        BusyA6, BusyB6;
  logic [5:0]  BusyVec6;

  regn_file #(.WIDTH(16), .NREGS(8), .AW(3), .ZERO_REG0(1'b1), .RESET_VAL(16'h0000)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .SetBusy(SetBusy), .BusyAddr(BusyAddr),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA), .BusyA(BusyA),
    .RdAddrB(RdAddrB), .RdDataB(RdDataB), .BusyB(BusyB),
    .BusyVec(BusyVec)
  );

  regn_file #(.WIDTH(16), .NREGS(6), .AW(3), .ZERO_REG0(1'b1), .RESET_VAL(16'h0000)) dut6 (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .SetBusy(SetBusy), .BusyAddr(BusyAddr),
    .RdAddrA(RdAddrA), .RdDataA(RdDataA6), .BusyA(BusyA6),
    .RdAddrB(RdAddrB), .RdDataB(RdDataB6), .BusyB(BusyB6),
    .BusyVec(BusyVec6)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    string       name;
    bit          six;
    logic [15:0] a;
    logic        ba;
    logic [15:0] b;
    logic        bb;
    logic [7:0]  vec;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [15:0] act,
                     input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%04h expected 0x%04h", nm, fld, act, want);
    end
  endtask

  // Monitor: the outputs are combinational, so each queued expectation is
  // checked against the outputs on the falling edge of the cycle where it was issued.
  always @(negedge Clock) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.six) begin
        chk(e.name, "RdDataA", RdDataA6, e.a);
        chk(e.name, "BusyA", {15'd0, BusyA6}, {15'd0, e.ba});
        chk(e.name, "RdDataB", RdDataB6, e.b);
        chk(e.name, "BusyB", {15'd0, BusyB6}, {15'd0, e.bb});
        chk(e.name, "BusyVec", {10'd0, BusyVec6}, {8'd0, e.vec});
      end else begin
        chk(e.name, "RdDataA", RdDataA, e.a);
        chk(e.name, "BusyA", {15'd0, BusyA}, {15'd0, e.ba});
        chk(e.name, "RdDataB", RdDataB, e.b);
        chk(e.name, "BusyB", {15'd0, BusyB}, {15'd0, e.bb});
        chk(e.name, "BusyVec", {8'd0, BusyVec}, {8'd0, e.vec});
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_rd(input string nm, input bit six,
                           input logic [15:0] a, input logic ba,
                           input logic [15:0] b, input logic bb,
                           input logic [7:0] vec);
    exp_t e;
    e.name = nm; e.six = six; e.a = a; e.ba = ba; e.b = b; e.bb = bb; e.vec = vec;
    sbq.push_back(e);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    step();
    WrEn = 1'b0;
  endtask

  task automatic do_setbusy(input logic [2:0] a);
    SetBusy = 1'b1; BusyAddr = a;
    step();
    SetBusy = 1'b0;
  endtask

  // Read both ports for one cycle with no write or set active.
  task automatic rd(input string nm, input bit six, input logic [2:0] aa,
                    input logic [2:0] ab, input logic [15:0] a, input logic ba,
                    input logic [15:0] b, input logic bb, input logic [7:0] vec);
    RdAddrA = aa; RdAddrB = ab;
    expect_rd(nm, six, a, ba, b, bb, vec);
    step();
  endtask

  logic [15:0] exp_byp;
  logic        exp_byp_busy;

  initial begin
    Resetn = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    SetBusy = 1'b0; BusyAddr = '0; RdAddrA = '0; RdAddrB = '0;
    step(); step();
    Resetn = 1'b1;

    // Fill registers and mark some busy, then reset once.
    for (int i = 1; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i) * 16'h0111);
    do_setbusy(3'd3);
    do_setbusy(3'd6);
    Resetn = 1'b0;
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'hDEAD; SetBusy = 1'b1; BusyAddr = 3'd4;
    step();
    Resetn = 1'b1; WrEn = 1'b0; SetBusy = 1'b0;
    for (int i = 0; i < 8; i++)
      rd($sformatf("reset_r%0d", i), 1'b0, 3'(i), 3'(7 - i), 16'h0, 1'b0, 16'h0, 1'b0, 8'h00);

    // Write/read, including the hardwired zero register.
    do_write(3'd3, 16'hBEEF);
    rd("wr_r3", 1'b0, 3'd3, 3'd3, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 8'h00);
    do_write(3'd0, 16'h1234);
    rd("wr_r0", 1'b0, 3'd0, 3'd3, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 8'h00);
    do_setbusy(3'd0);
    rd("busy_r0", 1'b0, 3'd0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00);

    // Scoreboard set, then cleared by the writeback.
    do_setbusy(3'd5);
    rd("set_r5", 1'b0, 3'd5, 3'd3, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 8'h20);
    do_write(3'd5, 16'h0042);
    rd("clr_r5", 1'b0, 3'd5, 3'd5, 16'h0042, 1'b0, 16'h0042, 1'b0, 8'h00);

    // Same-edge set and clear.
    do_setbusy(3'd2);
    rd("set_r2", 1'b0, 3'd2, 3'd1, 16'h0000, 1'b1, 16'h0000, 1'b0, 8'h04);
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'h0777; SetBusy = 1'b1; BusyAddr = 3'd2;
    step();
    WrEn = 1'b0; SetBusy = 1'b0;
    rd("same_addr", 1'b0, 3'd2, 3'd3, 16'h0777, 1'b1, 16'hBEEF, 1'b0, 8'h04);
    WrEn = 1'b1; WrAddr = 3'd2; WrData = 16'h0888; SetBusy = 1'b1; BusyAddr = 3'd6;
    step();
    WrEn = 1'b0; SetBusy = 1'b0;
    rd("diff_addr", 1'b0, 3'd2, 3'd6, 16'h0888, 1'b0, 16'h0000, 1'b1, 8'h40);
    do_write(3'd6, 16'h0666);
    rd("clr_r6", 1'b0, 3'd6, 3'd2, 16'h0666, 1'b0, 16'h0888, 1'b0, 8'h00);

    // Bypass / no-bypass behaviour during a write cycle.
    do_write(3'd4, 16'h0001);
`ifdef REGN_FILE_BYPASS_EN
    exp_byp = 16'h0099;
`else
    exp_byp = 16'h0001;
`endif
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 16'h0099; RdAddrA = 3'd4; RdAddrB = 3'd3;
    expect_rd("bypass", 1'b0, exp_byp, 1'b0, 16'hBEEF, 1'b0, 8'h00);
    step();
    WrEn = 1'b0;
    rd("after_byp", 1'b0, 3'd4, 3'd4, 16'h0099, 1'b0, 16'h0099, 1'b0, 8'h00);
    do_setbusy(3'd4);
`ifdef REGN_FILE_BYPASS_EN
    exp_byp = 16'h0100; exp_byp_busy = 1'b0;
`else
    exp_byp = 16'h0099; exp_byp_busy = 1'b1;
`endif
    WrEn = 1'b1; WrAddr = 3'd4; WrData = 16'h0100; RdAddrA = 3'd4; RdAddrB = 3'd5;
    expect_rd("bypass_busy", 1'b0, exp_byp, exp_byp_busy, 16'h0042, 1'b0, 8'h10);
    step();
    WrAddr = 3'd0; WrData = 16'h5555; RdAddrA = 3'd0; RdAddrB = 3'd4;
    expect_rd("bypass_r0", 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b0, 8'h00);
    step();
    WrEn = 1'b0;

    // Reset in the middle of a sequence drops pending busy bits.
    do_setbusy(3'd1);
    do_write(3'd7, 16'h7777);
    rd("pre_rst", 1'b0, 3'd7, 3'd1, 16'h7777, 1'b0, 16'h0000, 1'b1, 8'h02);
    Resetn = 1'b0;
    WrEn = 1'b1; WrAddr = 3'd7; WrData = 16'hAAAA; SetBusy = 1'b1; BusyAddr = 3'd2;
    step();
    Resetn = 1'b1; WrEn = 1'b0; SetBusy = 1'b0;
    rd("mid_rst", 1'b0, 3'd7, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 8'h00);

    // Out-of-range indices on the 6-entry bank.
    do_write(3'd5, 16'h0055);
    WrEn = 1'b1; WrAddr = 3'd7; WrData = 16'hFFFF; SetBusy = 1'b1; BusyAddr = 3'd6;
    RdAddrA = 3'd7; RdAddrB = 3'd5;
    expect_rd("oor_same", 1'b1, 16'h0000, 1'b0, 16'h0055, 1'b0, 8'h00);
    step();
    WrEn = 1'b0; SetBusy = 1'b0;
    rd("oor_after", 1'b1, 3'd7, 3'd5, 16'h0000, 1'b0, 16'h0055, 1'b0, 8'h00);
    do_setbusy(3'd5);
    rd("n6_busy5", 1'b1, 3'd6, 3'd5, 16'h0000, 1'b0, 16'h0055, 1'b1, 8'h20);

    step();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
